sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that sequences reads of the system-ID slave and compares the results against build-time expected values.
- Reads word 0 (system ID), then word 1 (timestamp).
- Publishes captured values plus ok/mismatch/timeout status to the boot/health logic.
- Sits between the sysid slave's control port and the status/LED or CSR block; one check runs automatically after reset and again on request.

Parameters:
- EXP_ID, 32'hACD51302, expected word at address 0
- EXP_TS, 32'h560CC2C4, expected word at address 1
- CHECK_TS, 1, 1 = read and compare timestamp; 0 = skip RD_TS, ts_ok forced 1
- TIMEOUT_CYC, 255, max cycles a read may stall on waitrequest (8-bit counter, 1..255)
- PERIOD_CYC, 50000000, re-check interval in clocks (used only under the optional feature)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check; ignored while busy
- avm_address  out  1  word address to sysid slave
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of each check
- id_ok  out  1  last captured ID == EXP_ID
- ts_ok  out  1  last captured timestamp == EXP_TS
- timeout_err  out  1  last check aborted by timeout
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FSM = IDLE, timeout counter 0.
  - Internal auto_pending = 1, so one check starts on the first clock after reset release.
- FSM states: IDLE, RD_ID, RD_TS, EVAL. Registered outputs; avm_address/avm_read decoded from state.
- IDLE:
  - busy=0.
  - start || auto_pending → RD_ID; clear auto_pending; clear timeout_err, id_ok, ts_ok.
- RD_ID:
  - avm_read=1, avm_address=0, busy=1.
  - On !avm_waitrequest: id_value ← avm_readdata, counter cleared; → RD_TS if CHECK_TS, else → EVAL.
- RD_TS:
  - avm_read=1, avm_address=1.
  - On !avm_waitrequest: ts_value ← avm_readdata → EVAL.
- Timeout:
  - In RD_ID/RD_TS, the counter increments each cycle waitrequest is high.
  - When it reaches TIMEOUT_CYC with waitrequest still high: timeout_err ← 1, avm_read drops next cycle, → EVAL.
  - A completion in the same cycle as the counter reaching TIMEOUT_CYC wins: data captured, no timeout.
- EVAL (one cycle):
  - id_ok ← !timeout_err && id_value==EXP_ID.
  - ts_ok ← CHECK_TS ? (!timeout_err && ts_value==EXP_TS) : 1.
  - done=1 for this cycle only; → IDLE.
- Latency: zero-wait slave with CHECK_TS=1 gives start → done in 4 cycles (IDLE→RD_ID→RD_TS→EVAL); 3 cycles with CHECK_TS=0.
- start while busy: dropped, not queued.
- Captured values persist until overwritten; on timeout, the stale value of the timed-out word is kept.
- Reset mid-read: avm_read drops immediately (async); the check reruns after release via auto_pending.

Optional Feature:
- Macro: SYSID_CHECKER_PERIODIC_EN.
- Defined: a 32-bit period counter runs in IDLE only and sets an internal request after PERIOD_CYC idle clocks. The counter clears when any check starts. Requests coinciding with start merge into one check.
- Undefined: no period counter; checks occur only at reset release and on start.

Decomposition:
- Package sysid_checker_pkg holds:
  - state enum (IDLE, RD_ID, RD_TS, EVAL)
  - address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1
  - default EXP_ID/EXP_TS constants
- One sub-module, sysid_checker_timeout: loadable saturating down-counter with clear/enable and an expired flag. The same instance pattern is reused for the periodic timer.
- FSM, capture registers and compare stay in the top.

Test Plan:
- Reset release, zero-wait slave returning 0xACD51302/0x560CC2C4 → done pulse 4 cycles after release; id_ok=1, ts_ok=1, timeout_err=0.
- start with slave returning ID 0xDEADBEEF → id_ok=0, ts_ok=1, id_value=0xDEADBEEF.
- waitrequest held high for 255 cycles in RD_ID → timeout_err=1, id_ok=0, ts_ok=0, avm_read low after timeout, done pulse.
- waitrequest high 254 cycles then low with data → no timeout, values captured, id_ok=1.
- start pulsed during RD_TS → ignored; exactly one done; reset_n asserted in RD_ID → outputs 0 at once; after release a fresh check completes.
- CHECK_TS=0 → address 1 never driven; done 3 cycles after start; ts_ok=1.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    EVAL  = 2'd3
  } state_e;

  // Word addresses inside the sysid slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Default build-time expectations
  localparam logic [31:0] DEF_EXP_ID = 32'hACD51302;
  localparam logic [31:0] DEF_EXP_TS = 32'h560CC2C4;

  // Counter widths for the read timeout and the periodic re-check timer
  localparam int TO_W     = 8;
  localparam int PERIOD_W = 32;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_checker_timeout.sv
// Loadable saturating down-counter. 'expired' fires on the enabled cycle that
// takes the count from 1 to 0, so a load of N expires on the N-th enabled cycle.
// A load also acts as the clear: it restarts the interval.
module sysid_checker_timeout #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Count down while enabled, holding at zero; load has priority
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign expired = en && !load && (cnt == W'(1));

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads sysid word 0 (ID) and word 1 (timestamp) and
// compares them against build-time values. One check runs after reset release
// and another on each 'start' seen while idle.
// Optional: define SYSID_CHECKER_PERIODIC_EN to also re-check every PERIOD_CYC
// idle clocks.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = DEF_EXP_ID,
  parameter logic [31:0] EXP_TS      = DEF_EXP_TS,
  parameter int          CHECK_TS    = 1,
  parameter int          TIMEOUT_CYC = 255,
  parameter int          PERIOD_CYC  = 50000000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_checker_if.master      avm,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout_err,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  state_e state, state_nx;
  logic   auto_pending;
  logic   period_hit;
  logic   go;
  logic   rd_active, rd_done, rd_tmo;
  logic   to_expired;

  assign go        = start || auto_pending || period_hit;
  assign rd_active = (state == RD_ID) || (state == RD_TS);
  assign rd_done   = rd_active && !avm.avm_waitrequest;
  // Completion is tested first, so data arriving on the last allowed cycle wins
  assign rd_tmo    = rd_active && avm.avm_waitrequest && to_expired;

  // Stall budget reloads while idle and again between the two reads
  sysid_checker_timeout #(.W(TO_W)) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     ((state == IDLE) || ((state == RD_ID) && rd_done)),
    .load_val (TO_W'(TIMEOUT_CYC)),
    .en       (rd_active && avm.avm_waitrequest),
    .expired  (to_expired)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  // Idle-only period timer; held loaded while a check runs so it restarts on each check
  sysid_checker_timeout #(.W(PERIOD_W)) u_period (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state != IDLE),
    .load_val (PERIOD_W'(PERIOD_CYC)),
    .en       (state == IDLE),
    .expired  (period_hit)
  );
`else
  // No periodic re-check; PERIOD_CYC is kept referenced so both builds share one parameter list
  assign period_hit = 1'b0 && (PERIOD_CYC != 0);
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (go) state_nx = RD_ID;
      RD_ID: if (rd_done)     state_nx = (CHECK_TS != 0) ? RD_TS : EVAL;
             else if (rd_tmo) state_nx = EVAL;
      RD_TS: if (rd_done || rd_tmo) state_nx = EVAL;
      EVAL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus strobes and busy decoded straight from the state register
  always_comb begin
    avm.avm_read    = 1'b0;
    avm.avm_address = SYSID_ADDR_ID;
    busy            = (state != IDLE);
    case (state)
      RD_ID: avm.avm_read = 1'b1;
      RD_TS: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = SYSID_ADDR_TS;
      end
      default: ;
    endcase
  end

  // Capture, compare and status; done is registered so it lines up with valid id_ok/ts_ok
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pending <= 1'b1;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout_err  <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
    end else begin
      done <= (state == EVAL);
      case (state)
        IDLE: if (go) begin
          auto_pending <= 1'b0;
          timeout_err  <= 1'b0;
          id_ok        <= 1'b0;
          ts_ok        <= 1'b0;
        end
        RD_ID: begin
          if (rd_done)     id_value    <= avm.avm_readdata;
          else if (rd_tmo) timeout_err <= 1'b1;
        end
        RD_TS: begin
          if (rd_done)     ts_value    <= avm.avm_readdata;
          else if (rd_tmo) timeout_err <= 1'b1;
        end
        EVAL: begin
          id_ok <= !timeout_err && (id_value == EXP_ID);
          ts_ok <= (CHECK_TS != 0) ? (!timeout_err && (ts_value == EXP_TS)) : 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two DUTs (timestamp check on / off) share a
// programmable-stall slave model; results are predicted from the read rules.
module tb_sysid_checker;

  localparam int          TMO    = 255;
  localparam int          LIMIT  = 1000;
  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h560CC2C4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Slave programming: stall cycles and data per word
  int          wi = 0, wt = 0;
  logic [31:0] di = EXP_ID, dt = EXP_TS;

  sysid_checker_if avm0();
  sysid_checker_if avm1();

  logic        busy0, done0, idok0, tsok0, tmo0;
  logic        busy1, done1, idok1, tsok1, tmo1;
  logic [31:0] idv0, tsv0, idv1, tsv1;
  int          stall0, stall1;

  // Slave: waitrequest for the programmed number of cycles, corrupted data while stalled
  assign avm0.avm_waitrequest = avm0.avm_read && (stall0 < (avm0.avm_address ? wt : wi));
  assign avm0.avm_readdata    = avm0.avm_waitrequest ? ~(avm0.avm_address ? dt : di) : (avm0.avm_address ? dt : di);
  assign avm1.avm_waitrequest = avm1.avm_read && (stall1 < (avm1.avm_address ? wt : wi));
  assign avm1.avm_readdata    = avm1.avm_waitrequest ? ~(avm1.avm_address ? dt : di) : (avm1.avm_address ? dt : di);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall0 <= 0;
    else if (avm0.avm_read && avm0.avm_waitrequest) stall0 <= stall0 + 1;
    else stall0 <= 0;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall1 <= 0;
    else if (avm1.avm_read && avm1.avm_waitrequest) stall1 <= stall1 + 1;
    else stall1 <= 0;
  end

  sysid_checker #(.EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .CHECK_TS(1), .TIMEOUT_CYC(TMO), .PERIOD_CYC(50000000)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm0),
    .busy(busy0), .done(done0), .id_ok(idok0), .ts_ok(tsok0), .timeout_err(tmo0),
    .id_value(idv0), .ts_value(tsv0));

  sysid_checker #(.EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .CHECK_TS(0), .TIMEOUT_CYC(TMO), .PERIOD_CYC(50000000)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm1),
    .busy(busy1), .done(done1), .id_ok(idok1), .ts_ok(tsok1), .timeout_err(tmo1),
    .id_value(idv1), .ts_value(tsv1));

  // Reference state and observations, index 0 = CHECK_TS=1, 1 = CHECK_TS=0
  logic [31:0] m_id[2], m_ts[2];
  logic        m_idok[2], m_tsok[2], m_tmo[2];
  int          m_lat[2];
  int          o_lat[2], o_nd[2], o_rd[2];
  logic        seen_ts1;

  function automatic logic [66:0] st(input int k);
    return (k == 0) ? {idok0, tsok0, tmo0, idv0, tsv0} : {idok1, tsok1, tmo1, idv1, tsv1};
  endfunction

  function automatic logic [69:0] zst(input int k);
    return (k == 0) ? {busy0, done0, idok0, tsok0, tmo0, avm0.avm_read, idv0, tsv0}
                    : {busy1, done1, idok1, tsok1, tmo1, avm1.avm_read, idv1, tsv1};
  endfunction

  // Predict one check: each read takes stall+1 cycles unless the stall reaches
  // TMO, in which case it aborts after TMO cycles; plus one cycle to leave
  // IDLE and one for the evaluate step before done shows.
  task automatic model_run(input int a, input int b, input logic [31:0] c, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      logic chk;
      logic tmo;
      int   lat;
      chk = (k == 0);
      tmo = 1'b0;
      lat = 2 + ((a < TMO) ? a + 1 : TMO);
      if (a >= TMO) tmo = 1'b1; else m_id[k] = c;
      if (chk && !tmo) begin
        lat += (b < TMO) ? b + 1 : TMO;
        if (b >= TMO) tmo = 1'b1; else m_ts[k] = d;
      end
      m_tmo[k]  = tmo;
      m_idok[k] = !tmo && (m_id[k] == EXP_ID);
      m_tsok[k] = chk ? (!tmo && (m_ts[k] == EXP_TS)) : 1'b1;
      m_lat[k]  = lat;
    end
  endtask

  // Optionally pulse start, then watch both DUTs until each has signalled done
  task automatic run_check(input logic use_start, input int pulse_at);
    for (int k = 0; k < 2; k++) begin
      o_lat[k] = -1; o_nd[k] = 0; o_rd[k] = -1;
    end
    seen_ts1 = 1'b0;
    start = use_start;
    for (int n = 1; n <= LIMIT; n++) begin
      @(posedge clock); #1;
      start = (n == pulse_at);
      if (avm0.avm_read) o_rd[0] = n;
      if (avm1.avm_read) o_rd[1] = n;
      if (avm1.avm_read && avm1.avm_address) seen_ts1 = 1'b1;
      if (done0) begin o_nd[0]++; if (o_lat[0] < 0) o_lat[0] = n; end
      if (done1) begin o_nd[1]++; if (o_lat[1] < 0) o_lat[1] = n; end
      if (o_lat[0] >= 0 && o_lat[1] >= 0 && n >= o_lat[0] + 3 && n >= o_lat[1] + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (zst(k) !== '0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got %h want 0", k, zst(k));
      end
      m_id[k] = '0; m_ts[k] = '0;
    end
    wi = 0; wt = 0; di = EXP_ID; dt = EXP_TS;
    @(posedge clock); #1; reset_n = 1'b1;
    run_check(1'b0, 0);
    model_run(wi, wt, di, dt);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL auto_latency dut%0d got %0d want %0d", k, o_lat[k], m_lat[k]); end
      vectors++;
      if (o_nd[k] !== 1) begin miscompares++; $display("FAIL auto_done_count dut%0d got %0d want 1", k, o_nd[k]); end
      vectors++;
      if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
        miscompares++;
        $display("FAIL auto_status dut%0d got %h want %h", k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
      end
    end
    vectors++;
    if (seen_ts1 !== 1'b0) begin miscompares++; $display("FAIL no_ts_read dut1 got %0b want 0", seen_ts1); end
  endtask

  task automatic test_id_mismatch();
    wi = $urandom_range(0, 3); wt = $urandom_range(0, 3); di = 32'hDEADBEEF; dt = EXP_TS;
    run_check(1'b1, 0);
    model_run(wi, wt, di, dt);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL mismatch_latency dut%0d got %0d want %0d", k, o_lat[k], m_lat[k]); end
      vectors++;
      if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
        miscompares++;
        $display("FAIL mismatch_status dut%0d got %h want %h", k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
      end
    end
  endtask

  // Stall boundaries: exactly TMO (abort), TMO-1 (completes), timeout on the timestamp read
  task automatic test_timeout();
    int sw_i[3] = '{255, 254, 0};
    int sw_t[3] = '{0, 254, 255};
    for (int s = 0; s < 3; s++) begin
      wi = sw_i[s]; wt = sw_t[s]; di = EXP_ID; dt = EXP_TS;
      run_check(1'b1, 0);
      model_run(wi, wt, di, dt);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL tmo%0d_latency dut%0d got %0d want %0d", s, k, o_lat[k], m_lat[k]); end
        vectors++;
        if (o_rd[k] !== m_lat[k] - 2) begin miscompares++; $display("FAIL tmo%0d_read_drop dut%0d got %0d want %0d", s, k, o_rd[k], m_lat[k] - 2); end
        vectors++;
        if (o_nd[k] !== 1) begin miscompares++; $display("FAIL tmo%0d_done_count dut%0d got %0d want 1", s, k, o_nd[k]); end
        vectors++;
        if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
          miscompares++;
          $display("FAIL tmo%0d_status dut%0d got %h want %h", s, k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      wi = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 260) : $urandom_range(0, 4);
      wt = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 260) : $urandom_range(0, 4);
      di = $urandom_range(0, 1) ? EXP_ID : $urandom;
      dt = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run_check(1'b1, 0);
      model_run(wi, wt, di, dt);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL rand%0d_latency dut%0d got %0d want %0d", r, k, o_lat[k], m_lat[k]); end
        vectors++;
        if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
          miscompares++;
          $display("FAIL rand%0d_status dut%0d got %h want %h", r, k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
        end
      end
      vectors++;
      if (seen_ts1 !== 1'b0) begin miscompares++; $display("FAIL rand%0d_no_ts_read dut1 got %0b want 0", r, seen_ts1); end
    end
  endtask

  // Second start lands while dut0 is in the timestamp read and dut1 is evaluating
  task automatic test_busy_start();
    wi = 0; wt = 0; di = EXP_ID; dt = $urandom;
    run_check(1'b1, 2);
    model_run(wi, wt, di, dt);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_nd[k] !== 1) begin miscompares++; $display("FAIL busy_done_count dut%0d got %0d want 1", k, o_nd[k]); end
      vectors++;
      if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL busy_latency dut%0d got %0d want %0d", k, o_lat[k], m_lat[k]); end
      vectors++;
      if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
        miscompares++;
        $display("FAIL busy_status dut%0d got %h want %h", k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
      end
    end
  endtask

  task automatic test_reset_mid();
    wi = 5; wt = 0; di = EXP_ID; dt = EXP_TS;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (avm0.avm_read !== 1'b1) begin miscompares++; $display("FAIL mid_read_active dut0 got %0b want 1", avm0.avm_read); end
    reset_n = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (zst(k) !== '0) begin
        miscompares++;
        $display("FAIL mid_reset_state dut%0d got %h want 0", k, zst(k));
      end
      m_id[k] = '0; m_ts[k] = '0;
    end
    wi = 0;
    @(posedge clock); #1; reset_n = 1'b1;
    run_check(1'b0, 0);
    model_run(wi, wt, di, dt);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_lat[k] !== m_lat[k]) begin miscompares++; $display("FAIL rerun_latency dut%0d got %0d want %0d", k, o_lat[k], m_lat[k]); end
      vectors++;
      if (st(k) !== {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]}) begin
        miscompares++;
        $display("FAIL rerun_status dut%0d got %h want %h", k, st(k), {m_idok[k], m_tsok[k], m_tmo[k], m_id[k], m_ts[k]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_mismatch();
    test_timeout();
    test_random();
    test_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
